lock_alarm_ctrl: RTL

LOCK_ALARM_CTRL -- requirements
Module: lock_alarm_ctrl

---
 rtl/lock_alarm_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/lock_alarm_ctrl.sv
// Lock alarm controller: counts wrong-password events, enforces a timed lockout and requests auto-relock.
// Optional build macro LOCK_ALARM_BLINK_EN makes Alarm_led blink at half-tick rate during lockout.
module lock_alarm_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int MAX_ERR  = 3,
  parameter int LOCK_SEC = 30,
  parameter int AUTO_SEC = 10
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Key_Done_Sig,
  input  logic       OPEN_sig,
  input  logic       ERROR_sig,
  input  logic       Close_sig,
  output logic       Key_Gated,
  output logic       Lock_out,
  output logic       Alarm_led,
  output logic [1:0] Err_cnt,
  output logic [7:0] Remain_sec,
  output logic       Relock_req,
  output logic [1:0] State_dbg
);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    OPENED  = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [1:0]    MAX_L     = 2'(MAX_ERR);
  localparam logic [7:0]    LOCK_L    = 8'(LOCK_SEC);
  localparam logic [7:0]    AUTO_L    = 8'(AUTO_SEC);

  // Assert is immediate, release is retimed to Clk through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    err_q, err_d;
  logic [7:0]    remain_q, remain_d;
  logic          relock_q, relock_d;
  logic          key_q, lock_q, alarm_q, alarm_d;
  logic          open_q, error_q, close_q;
  logic          open_rise_q, error_rise_q, close_rise_q;
  logic          tick;

  assign tick = (presc_q == TICK_LAST);

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    remain_d = remain_q;
    relock_d = 1'b0;
    case (state_q)
      NORMAL: begin
        remain_d = 8'd0;
        if (open_rise_q) begin
          state_d  = OPENED;
          err_d    = 2'd0;
          remain_d = AUTO_L;
        end else if (error_rise_q) begin
          if (err_q + 2'd1 == MAX_L) begin
            state_d  = LOCKOUT;
            err_d    = 2'd0;
            remain_d = LOCK_L;
          end else begin
            err_d = err_q + 2'd1;
          end
        end
      end
      OPENED: begin
        if (close_rise_q) begin
          state_d  = NORMAL;
          remain_d = 8'd0;
        end else if (tick) begin
          if (remain_q <= 8'd1) begin
            state_d  = NORMAL;
            remain_d = 8'd0;
            relock_d = 1'b1;
          end else begin
            remain_d = remain_q - 8'd1;
          end
        end
      end
      LOCKOUT: begin
        if (tick) begin
          if (remain_q <= 8'd1) begin
            state_d  = NORMAL;
            remain_d = 8'd0;
          end else begin
            remain_d = remain_q - 8'd1;
          end
        end
      end
      default: begin
        state_d  = NORMAL;
        err_d    = 2'd0;
        remain_d = 8'd0;
      end
    endcase
    // Every state entry restarts the second boundary.
    presc_d = ((state_d != state_q) || tick) ? '0 : presc_q + 1'b1;
  end

`ifdef LOCK_ALARM_BLINK_EN
  localparam logic [PW-1:0] HALF_LAST = PW'(TICK_DIV / 2 - 1);

  always_comb begin
    alarm_d = 1'b0;
    if (state_d == LOCKOUT) begin
      if (state_q != LOCKOUT)                    alarm_d = 1'b1;
      else if ((presc_q == HALF_LAST) || tick)   alarm_d = ~alarm_q;
      else                                       alarm_d = alarm_q;
    end
  end
`else
  assign alarm_d = (state_d == LOCKOUT);
`endif

  always_ff @(posedge Clk or posedge rst_int) begin
    if (rst_int) begin
      state_q      <= NORMAL;
      presc_q      <= '0;
      err_q        <= 2'd0;
      remain_q     <= 8'd0;
      relock_q     <= 1'b0;
      key_q        <= 1'b0;
      lock_q       <= 1'b0;
      alarm_q      <= 1'b0;
      open_q       <= 1'b0;
      error_q      <= 1'b0;
      close_q      <= 1'b0;
      open_rise_q  <= 1'b0;
      error_rise_q <= 1'b0;
      close_rise_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      err_q        <= err_d;
      remain_q     <= remain_d;
      relock_q     <= relock_d;
      key_q        <= Key_Done_Sig & (state_q != LOCKOUT);
      lock_q       <= (state_d == LOCKOUT);
      alarm_q      <= alarm_d;
      open_q       <= OPEN_sig;
      error_q      <= ERROR_sig;
      close_q      <= Close_sig;
      open_rise_q  <= OPEN_sig & ~open_q;
      error_rise_q <= ERROR_sig & ~error_q;
      close_rise_q <= Close_sig & ~close_q;
    end
  end

  assign Key_Gated  = key_q;
  assign Lock_out   = lock_q;
  assign Alarm_led  = alarm_q;
  assign Err_cnt    = err_q;
  assign Remain_sec = remain_q;
  assign Relock_req = relock_q;
  assign State_dbg  = state_q;

endmodule
